vu_onedet_seq: RTL and testbench
================================

# vu_onedet_seq

Sequencer that shares one 16-bit all-ones detector (`dp_onedet` instance, external to this block) across the lanes of a vector operand, one lane per cycle. It sits in the vector unit datapath next to the compare/flag logic. On a start request it:
- captures the full vector;
- presents each lane to the detector in turn;
- collects the per-lane results into a flag word;
- signals completion with a one-cycle done pulse.

## Interface
- `LANES`, 8, number of 16-bit lanes scanned (2..16).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset_l`  in  1  asynchronous active-low reset.
- `start`  in  1  request a scan; accepted only in IDLE or DONE.
- `vec_data`  in  16*LANES  operand; lane k is `vec_data[16k+15:16k]`; sampled only on the accepting edge.
- `det_data`  out  16  lane presented to the shared detector; 16'h0000 outside SCAN.
- `det_out`  in  1  detector result for `det_data` (combinational, same cycle).
- `busy`  out  1  high in SCAN.
- `done`  out  1  one-cycle pulse, high in DONE.
- `lane_flags`  out  LANES  bit k = 1 iff lane k was all ones.
- `all_ones`  out  1  AND of all `lane_flags` bits; valid when `done` is high, held until the next accept.

## Operation
**States:** IDLE, SCAN, DONE. A lane counter `cnt` runs 0..LANES-1, sized ceil(log2(LANES)) bits.

**IDLE:**
- `start` = 1 → capture `vec_data` into the operand register, clear `lane_flags` and `all_ones`, set `cnt` = 0, go to SCAN.
- Otherwise stay in IDLE.

**SCAN:**
- `det_data` = captured lane `cnt`.
- At the clock edge, `lane_flags[cnt]` ← `det_out`.
- If `cnt` = LANES-1: go to DONE and register `all_ones` ← AND of the final flag word, including the bit being written this cycle.
- Otherwise `cnt` increments.
- `start` is ignored in SCAN; no queuing.

**DONE:**
- Lasts exactly one cycle, with `done` = 1.
- `start` = 1 → accept as in IDLE and go directly to SCAN (back-to-back operation).
- Otherwise go to IDLE.

**Outputs after completion:** `lane_flags` and `all_ones` hold their values in IDLE until the next accept.

**Reset:** `reset_l` low at any time, including mid-scan, immediately forces:
- state IDLE, `cnt` 0, operand register 0;
- `lane_flags` 0, `all_ones` 0, `busy` 0, `done` 0, `det_data` 16'h0000.

No partial results survive reset.

## Timing
- Start accepted at edge T: SCAN occupies cycles T..T+LANES-1, with lane k on `det_data` in cycle T+k.
- `done` = 1 in cycle T+LANES; `lane_flags` and `all_ones` are valid in that cycle.
- Full latency, accept to `done`, is LANES+1 cycles (9 for LANES = 8).
- `busy` is high for exactly LANES cycles per scan.
- `det_out` is sampled in the same cycle `det_data` is driven. The detector path (mux + detector) must close within one cycle; no pipelining.
- `vec_data` may change freely after the accepting edge.
- Back-to-back: a start during DONE at edge T+LANES begins the next SCAN immediately, giving one scan per LANES+1 cycles.

## Configuration
Macro `VU_ONEDET_EARLY_EXIT_EN`.

**Defined:**
- In SCAN, `det_out` = 0 ends the scan: go to DONE at that edge.
- `lane_flags[cnt]` ← 0; all higher lanes remain 0; `all_ones` ← 0.
- Latency for a first failing lane j is j+2 cycles.

**Undefined:** every lane is always scanned; latency is fixed at LANES+1.

Interface and reset behaviour are identical in both builds.

## Test plan
- **All ones:** reset, then `vec_data` = all ones, `start` pulse at T → `det_data` = 16'hFFFF for cycles T..T+7, `done` at T+8, `lane_flags` = 8'hFF, `all_ones` = 1.
- **One lane fails:** lane 3 = 16'hFFFE, other lanes 16'hFFFF.
  - Without the macro → `done` at T+8, `lane_flags` = 8'hF7, `all_ones` = 0.
  - With the macro → `done` at T+4, `lane_flags` = 8'h07, `all_ones` = 0.
- **Back-to-back:** scan A (all ones), with `start` held high through DONE using new data lane 0 = 16'h0000 → second SCAN starts at T+9 with `busy` = 1, `lane_flags` cleared at that edge; second `done` at T+17 with `lane_flags` = 8'hFE.
- **Start while busy:** `start` pulses at T+2 and T+5 during SCAN → ignored; exactly one `done`, at T+8.
- **Reset mid-scan:** `reset_l` low in cycle T+4 → asynchronously `busy` = 0, `done` = 0, `lane_flags` = 0, `det_data` = 0. After release, a new start completes normally with correct flags.
- **Varying operand:** `vec_data` changed every cycle after accept → results reflect only the captured operand.

Source files
------------

// File: rtl/vu_onedet_seq.sv
// rtl/vu_onedet_seq.sv - time-shares one external 16-bit all-ones detector across vector lanes
// Optional macro VU_ONEDET_EARLY_EXIT_EN: stop the scan at the first lane that is not all ones.
module vu_onedet_seq #(
    parameter int LANES = 8
) (
    input  logic                  clk,
    input  logic                  reset_l,
    input  logic                  start,
    input  logic [16*LANES-1:0]   vec_data,
    output logic [15:0]           det_data,
    input  logic                  det_out,
    output logic                  busy,
    output logic                  done,
    output logic [LANES-1:0]      lane_flags,
    output logic                  all_ones
);

    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [15:0]       op_q [LANES];
    logic [LANES-1:0]  lane_flags_q;
    logic [LANES-1:0]  lane_flags_d;
    logic              all_ones_q;
    logic              busy_q;
    logic              done_q;
    logic              finish_scan;

    // Flag word as it will look after this cycle's write, so the final AND sees the last lane.
    always_comb begin
        lane_flags_d        = lane_flags_q;
        lane_flags_d[cnt_q] = det_out;
    end

`ifdef VU_ONEDET_EARLY_EXIT_EN
    assign finish_scan = (cnt_q == LAST) || !det_out;
`else
    assign finish_scan = (cnt_q == LAST);
`endif

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            for (int k = 0; k < LANES; k++) op_q[k] <= '0;
            lane_flags_q <= '0;
            all_ones_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        for (int k = 0; k < LANES; k++) op_q[k] <= vec_data[16*k +: 16];
                        lane_flags_q <= '0;
                        all_ones_q   <= 1'b0;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SCAN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    lane_flags_q <= lane_flags_d;
                    if (finish_scan) begin
                        all_ones_q <= &lane_flags_d;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign det_data   = busy_q ? op_q[cnt_q] : 16'h0000;
    assign busy       = busy_q;
    assign done       = done_q;
    assign lane_flags = lane_flags_q;
    assign all_ones   = all_ones_q;

endmodule

// File: tb/tb_vu_onedet_seq.sv
// tb/tb_vu_onedet_seq.sv - directed-vector bench for vu_onedet_seq with a behavioural detector
module tb_vu_onedet_seq;

    localparam int LANES = 8;

    logic                 clk;
    logic                 reset_l;
    logic                 start;
    logic [16*LANES-1:0]  vec_data;
    logic [15:0]          det_data;
    logic                 det_out;
    logic                 busy;
    logic                 done;
    logic [LANES-1:0]     lane_flags;
    logic                 all_ones;

    int n_chk  = 0;
    int n_pass = 0;

    vu_onedet_seq #(.LANES(LANES)) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .start      (start),
        .vec_data   (vec_data),
        .det_data   (det_data),
        .det_out    (det_out),
        .busy       (busy),
        .done       (done),
        .lane_flags (lane_flags),
        .all_ones   (all_ones)
    );

    assign det_out = (det_data == 16'hFFFF);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16*LANES-1:0] mk_vec(input int lane, input logic [15:0] val);
        logic [16*LANES-1:0] v;
        v = '1;
        if (lane >= 0) v[16*lane +: 16] = val;
        return v;
    endfunction

    // One scan: accept, follow lane by lane, then check the result and the one-cycle done.
    task automatic do_scan(input string tag, input logic [16*LANES-1:0] v,
                           input logic [7:0] ef, input logic ea, input int en,
                           input bit scramble, input bit poke);
        logic [16*LANES-1:0] cap;
        int n;
        cap      = v;
        vec_data = v;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n     = 0;
        while (!done && n < 40) begin
            if (busy && n < LANES) chk({tag, "_det"}, 32'(det_data), 32'(cap[16*n +: 16]));
            if (scramble) vec_data = {$urandom, $urandom, $urandom, $urandom};
            if (poke) start = (n == 1 || n == 4);
            tick();
            n++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(n), 32'(en));
        chk({tag, "_flags"}, 32'(lane_flags), 32'(ef));
        chk({tag, "_all"}, 32'(all_ones), 32'(ea));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
        chk({tag, "_flags_held"}, 32'(lane_flags), 32'(ef));
    endtask

    initial begin
        int n;
        reset_l  = 1'b0;
        start    = 1'b0;
        vec_data = '0;
        repeat (2) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", 32'(lane_flags), 32'd0);
        chk("rst_all", 32'(all_ones), 32'd0);
        chk("rst_det", 32'(det_data), 32'd0);
        reset_l = 1'b1;
        tick();

        do_scan("ones", mk_vec(-1, 16'h0), 8'hFF, 1'b1, 8, 1'b0, 1'b0);
`ifdef VU_ONEDET_EARLY_EXIT_EN
        do_scan("lane3", mk_vec(3, 16'hFFFE), 8'h07, 1'b0, 4, 1'b0, 1'b0);
        do_scan("lane0", mk_vec(0, 16'h0000), 8'h00, 1'b0, 1, 1'b0, 1'b0);
        do_scan("vary", mk_vec(5, 16'h1234), 8'h1F, 1'b0, 6, 1'b1, 1'b0);
`else
        do_scan("lane3", mk_vec(3, 16'hFFFE), 8'hF7, 1'b0, 8, 1'b0, 1'b0);
        do_scan("lane0", mk_vec(0, 16'h0000), 8'hFE, 1'b0, 8, 1'b0, 1'b0);
        do_scan("vary", mk_vec(5, 16'h1234), 8'hDF, 1'b0, 8, 1'b1, 1'b0);
`endif
        do_scan("lane7", mk_vec(7, 16'h7FFF), 8'h7F, 1'b0, 8, 1'b0, 1'b0);
        do_scan("poke", mk_vec(-1, 16'h0), 8'hFF, 1'b1, 8, 1'b0, 1'b1);

        // Back-to-back: start held through DONE with new data.
        vec_data = mk_vec(-1, 16'h0);
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        chk("b2b_lat_a", 32'(n), 32'd8);
        chk("b2b_flags_a", 32'(lane_flags), 32'hFF);
        vec_data = mk_vec(0, 16'h0000);
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_cleared", 32'(lane_flags), 32'd0);
        chk("b2b_det0", 32'(det_data), 32'h0000);
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
`ifdef VU_ONEDET_EARLY_EXIT_EN
        chk("b2b_lat_b", 32'(n), 32'd1);
        chk("b2b_flags_b", 32'(lane_flags), 32'h00);
`else
        chk("b2b_lat_b", 32'(n), 32'd8);
        chk("b2b_flags_b", 32'(lane_flags), 32'hFE);
`endif
        chk("b2b_all_b", 32'(all_ones), 32'd0);
        tick();

        // Reset mid-scan must clear everything without a clock edge.
        vec_data = mk_vec(-1, 16'h0);
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        #2;
        reset_l = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_flags", 32'(lane_flags), 32'd0);
        chk("mid_det", 32'(det_data), 32'd0);
        @(negedge clk);
        reset_l = 1'b1;
        tick();
        chk("mid_idle", 32'(busy), 32'd0);
        do_scan("post", mk_vec(6, 16'h0F0F), 8'hBF, 1'b0,
`ifdef VU_ONEDET_EARLY_EXIT_EN
                7,
`else
                8,
`endif
                1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
